// File: rtl/cordic_seq.sv
// cordic_seq: job sequencer between the APB register block and the shared
// iterative CORDIC core. Folds operands into the core's convergence range,
// runs one or two watchdog-guarded core passes and assembles the results.
//
// Handshakes: every pulse output (clear_control_bit, core_start, core_abort,
// sys_cordic_done) is high for exactly one cycle; core_done is only honoured
// in a WAIT state and its data (core_x/y/z) is taken in that same cycle.
module cordic_seq #(
   parameter int TIMEOUT = 64
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic [5:0]  CONTROL,
   input  logic [31:0] PROG_A,
   input  logic [31:0] PROG_B,
   input  logic [31:0] PROG_C,
   input  logic [4:0]  XYFRACBASE,
   input  logic [4:0]  PHASEFRACBASE,
   output logic        clear_control_bit,
   output logic        sys_cordic_done,
   output logic [31:0] cordic_out1,
   output logic [31:0] cordic_out2,
   output logic [31:0] cordic_out3,
   output logic [31:0] cordic_out4,
   output logic [31:0] cordic_out5,
   output logic [31:0] cordic_out6,
   output logic        core_start,
   output logic        core_mode,
   output logic [31:0] core_x0,
   output logic [31:0] core_y0,
   output logic [31:0] core_z0,
   output logic        core_abort,
   input  logic        core_done,
   input  logic [31:0] core_x,
   input  logic [31:0] core_y,
   input  logic [31:0] core_z,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE, S_LAUNCH1, S_WAIT1, S_LAUNCH2, S_WAIT2, S_DONE
   } state_t;

   typedef struct packed {
      logic        f;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] z;
   } ops_t;

   // pi/2 in Q28; scaled down for smaller phase formats
   localparam logic [31:0] HP_Q28  = 32'h1921FB54;
   localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

   // Rotate-mode quarter-turn fold; subtraction from zero wraps 0x80000000 onto itself
   function automatic ops_t fold_rot(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z, input logic [31:0] hp);
      ops_t r;
      r.f = 1'b0; r.x = x; r.y = y; r.z = z;
      if ($signed(z) > $signed(hp)) begin
         r.f = 1'b1; r.x = 32'd0 - y; r.y = x; r.z = z - hp;
      end else if ($signed(z) < $signed(32'd0 - hp)) begin
         r.f = 1'b1; r.x = y; r.y = 32'd0 - x; r.z = z + hp;
      end
      return r;
   endfunction

   // Vector-mode half-turn fold; the pi offset sign follows the original y
   function automatic ops_t fold_vec(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] pi);
      ops_t r;
      r.f = x[31]; r.x = x; r.y = y; r.z = 32'd0;
      if (x[31]) begin
         r.x = 32'd0 - x;
         r.y = 32'd0 - y;
         r.z = y[31] ? (32'd0 - pi) : pi;
      end
      return r;
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   state_t      state_q, state_d;
   logic        clr_q, clr_d, abort_q, abort_d, mode_q, mode_d;
   logic        fold1_q, fold1_d, fold2_q, fold2_d;
   logic [2:0]  op_q, op_d;
   logic [31:0] c_q, c_d, hp_q, hp_d;
   logic [31:0] x0_q, x0_d, y0_q, y0_d, z0_q, z0_d, p1x_q, p1x_d, p1z_q, p1z_d;
   logic [15:0] wd_q, wd_d, cyc_q, cyc_d;
   logic [31:0] out1_q, out1_d, out2_q, out2_d, out3_q, out3_d;
   logic [31:0] out4_q, out4_d, out5_q, out5_d, out6_q, out6_d;
   logic        finish, tmo;
   logic [4:0]  pfb;
   logic [31:0] hp_now;
   ops_t        fo;

   // Next-state, operand folding and result assembly
   always_comb begin
      state_d = state_q; clr_d = 1'b0; abort_d = 1'b0; mode_d = mode_q;
      fold1_d = fold1_q; fold2_d = fold2_q; op_d = op_q; c_d = c_q; hp_d = hp_q;
      x0_d = x0_q; y0_d = y0_q; z0_d = z0_q; p1x_d = p1x_q; p1z_d = p1z_q;
      wd_d = wd_q; cyc_d = cyc_q;
      out1_d = out1_q; out2_d = out2_q; out3_d = out3_q;
      out4_d = out4_q; out5_d = out5_q; out6_d = out6_q;
      finish = 1'b0; tmo = 1'b0; fo = '0;
      pfb    = (PHASEFRACBASE > 5'd28) ? 5'd28 : PHASEFRACBASE;
      hp_now = HP_Q28 >> (5'd28 - pfb);
      case (state_q)
         S_IDLE: begin
            if (CONTROL[0]) begin
               clr_d = 1'b1; op_d = CONTROL[3:1]; c_d = PROG_C; hp_d = hp_now;
               fold2_d = 1'b0; p1x_d = 32'd0; p1z_d = 32'd0; wd_d = 16'd0; cyc_d = 16'd0;
               if (CONTROL[3]) begin
                  state_d = S_DONE;
                  out1_d = 32'd0; out2_d = 32'd0; out3_d = 32'd0;
                  out4_d = 32'd0; out5_d = 32'd0; out6_d = 32'h4000_0000;
               end else begin
                  case (CONTROL[2:1])
                     2'b00:   fo = fold_rot(PROG_A, PROG_B, PROG_C, hp_now);
                     2'b10:   fo = fold_rot(32'd1 << XYFRACBASE, 32'd0, PROG_A, hp_now);
                     default: fo = fold_vec(PROG_A, PROG_B, hp_now << 1);
                  endcase
                  x0_d = fo.x; y0_d = fo.y; z0_d = fo.z; fold1_d = fo.f;
                  mode_d = CONTROL[1];
                  state_d = S_LAUNCH1;
               end
            end
         end
         S_LAUNCH1, S_LAUNCH2: begin
            wd_d = 16'd0;
            cyc_d = sat_inc(cyc_q);
            state_d = (state_q == S_LAUNCH1) ? S_WAIT1 : S_WAIT2;
         end
         S_WAIT1, S_WAIT2: begin
            wd_d = wd_q + 16'd1;
            cyc_d = sat_inc(cyc_q);
            if (core_done) begin
               if (state_q == S_WAIT1 && op_q[1:0] == 2'b11) begin
                  // POLAR2: second pass rotates the pass-1 magnitude by angle + C
                  fo = fold_rot(core_x, 32'd0, core_z + c_q, hp_q);
                  p1x_d = core_x; p1z_d = core_z;
                  x0_d = fo.x; y0_d = fo.y; z0_d = fo.z; fold2_d = fo.f;
                  mode_d = 1'b0;
                  state_d = S_LAUNCH2;
               end else begin
                  finish = 1'b1;
               end
            end else if (wd_q + 16'd1 == WD_LAST) begin
               finish = 1'b1;
               tmo = 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (finish) begin
         state_d = S_DONE;
         abort_d = tmo;
         out1_d = tmo ? 32'd0 : core_x;
         out2_d = tmo ? 32'd0 : core_y;
         out3_d = tmo ? 32'd0 : core_z;
         out4_d = p1x_q;
         out5_d = p1z_q;
         out6_d = {tmo, 1'b0, fold1_q, fold2_q, 12'd0, sat_inc(cyc_q)};
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q <= S_IDLE; clr_q <= 1'b0; abort_q <= 1'b0; mode_q <= 1'b0;
         fold1_q <= 1'b0; fold2_q <= 1'b0; op_q <= 3'd0; c_q <= 32'd0; hp_q <= 32'd0;
         x0_q <= 32'd0; y0_q <= 32'd0; z0_q <= 32'd0; p1x_q <= 32'd0; p1z_q <= 32'd0;
         wd_q <= 16'd0; cyc_q <= 16'd0;
         out1_q <= 32'd0; out2_q <= 32'd0; out3_q <= 32'd0;
         out4_q <= 32'd0; out5_q <= 32'd0; out6_q <= 32'd0;
      end else begin
         state_q <= state_d; clr_q <= clr_d; abort_q <= abort_d; mode_q <= mode_d;
         fold1_q <= fold1_d; fold2_q <= fold2_d; op_q <= op_d; c_q <= c_d; hp_q <= hp_d;
         x0_q <= x0_d; y0_q <= y0_d; z0_q <= z0_d; p1x_q <= p1x_d; p1z_q <= p1z_d;
         wd_q <= wd_d; cyc_q <= cyc_d;
         out1_q <= out1_d; out2_q <= out2_d; out3_q <= out3_d;
         out4_q <= out4_d; out5_q <= out5_d; out6_q <= out6_d;
      end
   end

   assign clear_control_bit = clr_q;
   assign sys_cordic_done   = (state_q == S_DONE);
   assign core_start        = (state_q == S_LAUNCH1) || (state_q == S_LAUNCH2);
   assign core_abort        = abort_q;
   assign core_mode         = mode_q;
   assign core_x0           = x0_q;
   assign core_y0           = y0_q;
   assign core_z0           = z0_q;
   assign cordic_out1       = out1_q;
   assign cordic_out2       = out2_q;
   assign cordic_out3       = out3_q;
   assign cordic_out4       = out4_q;
   assign cordic_out5       = out5_q;
   assign cordic_out6       = out6_q;
   assign dbg_state         = state_q;

endmodule

// File: tb/tb_cordic_seq.sv
// Bench for cordic_seq: a core stub with per-launch latency, a vector table
// of jobs with hand-derived operands/status, and hand-written sequences for
// reset mid-job, stray core_done and a start held across DONE.
module tb_cordic_seq;

   logic        PCLK = 1'b0;
   logic        PRESET;
   logic [5:0]  CONTROL;
   logic [31:0] PROG_A, PROG_B, PROG_C;
   logic [4:0]  XYFRACBASE, PHASEFRACBASE;
   logic        clear_control_bit, sys_cordic_done, core_start, core_mode, core_abort;
   logic [31:0] cordic_out1, cordic_out2, cordic_out3, cordic_out4, cordic_out5, cordic_out6;
   logic [31:0] core_x0, core_y0, core_z0;
   logic        core_done = 1'b0;
   logic [31:0] core_x = 32'd0, core_y = 32'd0, core_z = 32'd0;
   logic [2:0]  dbg_state;

   cordic_seq #(.TIMEOUT(64)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .CONTROL(CONTROL),
      .PROG_A(PROG_A), .PROG_B(PROG_B), .PROG_C(PROG_C),
      .XYFRACBASE(XYFRACBASE), .PHASEFRACBASE(PHASEFRACBASE),
      .clear_control_bit(clear_control_bit), .sys_cordic_done(sys_cordic_done),
      .cordic_out1(cordic_out1), .cordic_out2(cordic_out2), .cordic_out3(cordic_out3),
      .cordic_out4(cordic_out4), .cordic_out5(cordic_out5), .cordic_out6(cordic_out6),
      .core_start(core_start), .core_mode(core_mode),
      .core_x0(core_x0), .core_y0(core_y0), .core_z0(core_z0),
      .core_abort(core_abort), .core_done(core_done),
      .core_x(core_x), .core_y(core_y), .core_z(core_z),
      .dbg_state(dbg_state)
   );

   // ---------------- clock / reset / cycle count ----------------
   always #5 PCLK = ~PCLK;
   int cyc = 0;
   always @(posedge PCLK) cyc <= cyc + 1;

   // ---------------- core stub ----------------
   int          stub_lat [0:63];
   logic [95:0] stub_resp[0:63];
   int          stub_n = 0, stub_cur = 0, stub_cnt = 0;
   logic        stray_req = 1'b0;

   always @(posedge PCLK) begin
      core_done <= stray_req;
      if (stub_cnt > 0) begin
         stub_cnt <= stub_cnt - 1;
         if (stub_cnt == 1) begin
            core_done <= 1'b1;
            {core_x, core_y, core_z} <= stub_resp[stub_cur];
         end
      end
      if (core_start) begin
         stub_cur <= stub_n;
         stub_n   <= stub_n + 1;
         if (stub_lat[stub_n] == 1) begin
            core_done <= 1'b1;
            {core_x, core_y, core_z} <= stub_resp[stub_n];
         end else if (stub_lat[stub_n] > 1) begin
            stub_cnt <= stub_lat[stub_n] - 1;
         end
      end
      if (PRESET) stub_cnt <= 0;
   end

   // ---------------- scoreboard ----------------
   logic [96:0]  exp_launch_q[$];
   logic [192:0] exp_done_q[$];
   int checks = 0, failures = 0;
   int n_start = 0, n_clr = 0, n_abort = 0, n_done = 0, t_clr = 0, t_done = 0;

   task automatic check(input string name, input logic [192:0] act, input logic [192:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic miss(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=no_event required=event", name);
   endtask

   // One cycle: wait for the falling edge and score whatever the DUT shows
   task automatic tick();
      logic [96:0]  el;
      logic [192:0] ed;
      @(negedge PCLK);
      if (core_start) begin
         n_start++;
         if (exp_launch_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL launch_unexpected actual=%h required=none", {core_mode, core_x0, core_y0, core_z0});
         end else begin
            el = exp_launch_q.pop_front();
            check("launch_ops", 193'({core_mode, core_x0, core_y0, core_z0}), 193'(el));
         end
      end
      if (clear_control_bit) begin n_clr++; t_clr = cyc; end
      if (core_abort) n_abort++;
      if (sys_cordic_done) begin
         n_done++; t_done = cyc;
         if (exp_done_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL done_unexpected actual=%h required=none", cordic_out6);
         end else begin
            ed = exp_done_q.pop_front();
            check("results", {core_abort, cordic_out1, cordic_out2, cordic_out3,
                              cordic_out4, cordic_out5, cordic_out6}, ed);
         end
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [2:0]  op;
      logic [31:0] a, b, c;
      logic [4:0]  xyfb, pfb;
      int          l1, l2;       // core latency per pass, 0 = never answers
      logic [95:0] r1, r2;       // core responses {x,y,z}
      logic [96:0] ln1, ln2;     // expected {mode,x0,y0,z0} per launch
      logic [31:0] st;           // expected out6
      int          lat;          // start-sampled cycle to sys_cordic_done
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a, b, c,
                               input logic [4:0] xyfb, pfb, input int l1, l2,
                               input logic [95:0] r1, r2, input logic [96:0] ln1, ln2,
                               input logic [31:0] st, input int lat);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.c = c; v.xyfb = xyfb; v.pfb = pfb;
      v.l1 = l1; v.l2 = l2; v.r1 = r1; v.r2 = r2; v.ln1 = ln1; v.ln2 = ln2;
      v.st = st; v.lat = lat;
      return v;
   endfunction

   // Program the stub from slot base and queue the expected launches/results
   task automatic exp_push(input vec_t v, input int base, output int nl, output logic to);
      int          np;
      logic [95:0] rl;
      logic [95:0] o123;
      logic [63:0] o45;
      np = v.op[2] ? 0 : ((v.op[1:0] == 2'b11) ? 2 : 1);
      stub_lat[base] = v.l1; stub_resp[base] = v.r1;
      stub_lat[base + 1] = v.l2; stub_resp[base + 1] = v.r2;
      nl = 0;
      if (np >= 1) begin exp_launch_q.push_back(v.ln1); nl++; end
      if (np == 2 && v.l1 != 0) begin exp_launch_q.push_back(v.ln2); nl++; end
      to = (np >= 1 && v.l1 == 0) || (np == 2 && v.l2 == 0);
      rl = (np == 2) ? v.r2 : v.r1;
      o123 = (np == 0 || to) ? 96'd0 : rl;
      o45 = (np == 2 && v.l1 != 0) ? {v.r1[95:64], v.r1[31:0]} : 64'd0;
      exp_done_q.push_back({to, o123, o45, v.st});
   endtask

   task automatic drive_job(input vec_t v);
      PROG_A = v.a; PROG_B = v.b; PROG_C = v.c;
      XYFRACBASE = v.xyfb; PHASEFRACBASE = v.pfb;
      CONTROL = {2'($urandom_range(0, 3)), v.op, 1'b1};
   endtask

   task automatic run_vec(input vec_t v);
      int   t0, d0, s0, a0, c0, nl;
      logic to;
      exp_push(v, n_start, nl, to);
      drive_job(v);
      t0 = cyc; d0 = n_done; s0 = n_start; a0 = n_abort; c0 = n_clr;
      for (int k = 0; k < 200 && n_done == d0; k++) begin
         tick();
         if (n_clr != c0) CONTROL[0] = 1'b0;
      end
      if (n_done == d0) miss("done_wait");
      else begin
         check("done_latency", 193'(t_done - t0), 193'(v.lat));
         check("clear_cycle", 193'(t_clr - t0), 193'd1);
         check("launch_count", 193'(n_start - s0), 193'(nl));
         check("abort_count", 193'(n_abort - a0), 193'(to));
      end
      CONTROL[0] = 1'b0;
      tick();
   endtask

   // ---------------- test ----------------
   initial begin
      int   d0, s0, a0, c0, t_first, nl;
      logic to;
      vec_t vb;
      for (int i = 0; i < 64; i++) begin stub_lat[i] = 0; stub_resp[i] = 96'd0; end
      PRESET = 1'b1; CONTROL = 6'd0; PROG_A = 32'd0; PROG_B = 32'd0; PROG_C = 32'd0;
      XYFRACBASE = 5'd16; PHASEFRACBASE = 5'd28;
      repeat (3) tick();
      check("reset_outs", {1'b0, cordic_out1, cordic_out2, cordic_out3, cordic_out4,
                           cordic_out5, cordic_out6}, 193'd0);
      check("reset_ctl", 193'({clear_control_bit, sys_cordic_done, core_start, core_mode,
                               core_abort, core_x0, core_y0, core_z0, dbg_state}), 193'd0);
      PRESET = 1'b0;
      tick();

      // op a b c xyfb pfb l1 l2 r1 r2 ln1 ln2 status latency
      vecs.push_back(mk(3'd0, 32'h10000, 32'h0, 32'h30000000, 5'd16, 5'd28, 3, 0,
                        {32'h8000, 32'hDDB3, 32'h0}, 96'd0, {1'b0, 32'h0, 32'h10000, 32'h16DE04AC}, 97'd0, 32'h20000004, 5));
      vecs.push_back(mk(3'd0, 32'h1234, 32'h5678, 32'h10000000, 5'd16, 5'd28, 1, 0,
                        {32'd1, 32'd2, 32'd3}, 96'd0, {1'b0, 32'h1234, 32'h5678, 32'h10000000}, 97'd0, 32'h2, 3));
      vecs.push_back(mk(3'd0, 32'h100, 32'h200, 32'hE0000000, 5'd16, 5'd28, 2, 0,
                        {32'd4, 32'd5, 32'd6}, 96'd0, {1'b0, 32'h200, 32'hFFFFFF00, 32'hF921FB54}, 97'd0, 32'h20000003, 4));
      vecs.push_back(mk(3'd1, 32'hFFFF0000, 32'h10000, 32'h777, 5'd16, 5'd28, 4, 0,
                        {32'd7, 32'd8, 32'd9}, 96'd0, {1'b1, 32'h10000, 32'hFFFF0000, 32'h3243F6A8}, 97'd0, 32'h20000005, 6));
      vecs.push_back(mk(3'd1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 5'd16, 5'd28, 1, 0,
                        {32'd10, 32'd11, 32'd12}, 96'd0, {1'b1, 32'h80000000, 32'h1, 32'hCDBC0958}, 97'd0, 32'h20000002, 3));
      vecs.push_back(mk(3'd1, 32'h5, 32'hFFFFFFF0, 32'h0, 5'd16, 5'd28, 2, 0,
                        {32'd13, 32'd14, 32'd15}, 96'd0, {1'b1, 32'h5, 32'hFFFFFFF0, 32'h0}, 97'd0, 32'h3, 4));
      vecs.push_back(mk(3'd2, 32'h08000000, 32'h0, 32'h0, 5'd16, 5'd28, 2, 0,
                        {32'd16, 32'd17, 32'd18}, 96'd0, {1'b0, 32'h10000, 32'h0, 32'h08000000}, 97'd0, 32'h3, 4));
      vecs.push_back(mk(3'd2, 32'h20000000, 32'h0, 32'h0, 5'd12, 5'd30, 2, 0,
                        {32'd19, 32'd20, 32'd21}, 96'd0, {1'b0, 32'h0, 32'h1000, 32'h06DE04AC}, 97'd0, 32'h20000003, 4));
      vecs.push_back(mk(3'd0, 32'h3, 32'h7, 32'h20000, 5'd16, 5'd16, 1, 0,
                        {32'd22, 32'd23, 32'd24}, 96'd0, {1'b0, 32'hFFFFFFF9, 32'h3, 32'h6DE1}, 97'd0, 32'h20000002, 3));
      vecs.push_back(mk(3'd3, 32'hFFFF0000, 32'h0, 32'h10000000, 5'd16, 5'd28, 2, 3,
                        {32'h9B74, 32'h1, 32'h3243F6A8}, {32'hAA, 32'hBB, 32'hCC},
                        {1'b1, 32'h10000, 32'h0, 32'h3243F6A8}, {1'b0, 32'h0, 32'h9B74, 32'h2921FB54}, 32'h30000007, 8));
      vecs.push_back(mk(3'd3, 32'h10000, 32'h10000, 32'h01000000, 5'd16, 5'd28, 1, 1,
                        {32'h16A09, 32'h5, 32'h0C90FDAA}, {32'd1, 32'd2, 32'd3},
                        {1'b1, 32'h10000, 32'h10000, 32'h0}, {1'b0, 32'h16A09, 32'h0, 32'h0D90FDAA}, 32'h4, 5));
      vecs.push_back(mk(3'd4, 32'h1, 32'h2, 32'h3, 5'd16, 5'd28, 0, 0,
                        96'd0, 96'd0, 97'd0, 97'd0, 32'h40000000, 1));
      vecs.push_back(mk(3'd7, 32'h1, 32'h2, 32'h3, 5'd16, 5'd28, 0, 0,
                        96'd0, 96'd0, 97'd0, 97'd0, 32'h40000000, 1));
      // watchdog expiry, then core_done landing on the expiry cycle
      vecs.push_back(mk(3'd0, 32'h1, 32'h2, 32'h0, 5'd16, 5'd28, 0, 0,
                        96'd0, 96'd0, {1'b0, 32'h1, 32'h2, 32'h0}, 97'd0, 32'h80000040, 65));
      vecs.push_back(mk(3'd0, 32'h1, 32'h2, 32'h0, 5'd16, 5'd28, 63, 0,
                        {32'h11, 32'h22, 32'h33}, 96'd0, {1'b0, 32'h1, 32'h2, 32'h0}, 97'd0, 32'h40, 65));

      foreach (vecs[i]) run_vec(vecs[i]);

      // stray core_done while idle must be ignored
      d0 = n_done; s0 = n_start;
      stray_req = 1'b1; tick(); stray_req = 1'b0;
      repeat (4) tick();
      check("stray_done_ignored", 193'({n_done - d0, n_start - s0}), 193'd0);

      // reset in WAIT1: no stale done/abort, then a normal job
      stub_lat[n_start] = 0;
      exp_launch_q.push_back({1'b0, 32'h1, 32'h2, 32'h0});
      PROG_A = 32'h1; PROG_B = 32'h2; PROG_C = 32'h0; CONTROL = 6'b000001;
      c0 = n_clr;
      for (int k = 0; k < 5 && n_clr == c0; k++) tick();
      CONTROL = 6'd0;
      repeat (5) tick();
      PRESET = 1'b1; tick();
      check("midjob_reset_outs", {1'b0, cordic_out1, cordic_out2, cordic_out3, cordic_out4,
                                  cordic_out5, cordic_out6}, 193'd0);
      check("midjob_reset_state", 193'({dbg_state, core_start, core_abort, sys_cordic_done, core_x0}), 193'd0);
      PRESET = 1'b0;
      d0 = n_done; a0 = n_abort;
      repeat (80) tick();
      check("no_stale_done", 193'({n_done - d0, n_abort - a0}), 193'd0);
      run_vec(vecs[1]);

      // start held through DONE: second job accepted in the cycle after IDLE
      vb = vecs[1];
      exp_push(vb, n_start, nl, to);
      vb.r1 = {32'hA1, 32'hB2, 32'hC3};
      exp_push(vb, n_start + 1, nl, to);
      drive_job(vb);
      CONTROL[0] = 1'b1;
      d0 = n_done; c0 = n_clr; t_first = 0;
      for (int k = 0; k < 50 && n_done < d0 + 2; k++) begin
         tick();
         if (n_done == d0 + 1 && t_first == 0) t_first = t_done;
         if (n_clr >= c0 + 2) CONTROL[0] = 1'b0;
      end
      CONTROL[0] = 1'b0;
      repeat (4) tick();
      check("held_start_jobs", 193'(n_done - d0), 193'd2);
      check("held_start_clears", 193'(n_clr - c0), 193'd2);
      check("held_start_reaccept", 193'(t_clr - t_first), 193'd2);

      check("launch_queue_drained", 193'(exp_launch_q.size()), 193'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
